fifo_traffic_gen: RTL and testbench

//  Synthesizable stimulus source that drives the write/read side of the synchronous FIFO (data_in, wr_en, rd_en).

---
 rtl/shared_pkg.sv | 22 ++
 rtl/lfsr32.sv | 22 ++
 rtl/fifo_traffic_gen.sv | 193 +++++++++++++++++++
 tb/tb_fifo_traffic_gen.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared types for the FIFO traffic generator.
// Mode and state encodings plus the LFSR feedback mask.
package shared_pkg;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    ALTERNATE,
    RANDOM
  } gen_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } gen_state_e;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR used as the data and random-op source.
// Loads seed on reset, steps once per enabled cycle.
module lfsr32
  import shared_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  // shift right, fold feedback into the tap positions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= seed;
    end else if (en) begin
      q <= {1'b0, q[31:1]} ^ ({32{q[0]}} & LFSR_TAPS);
    end
  end

endmodule

// File: rtl/fifo_traffic_gen.sv
// Active stimulus source for the synchronous FIFO write/read ports.
// Each op slot's enables are registered, so slot k drives the FIFO in RUN cycle k.
module fifo_traffic_gen
  import shared_pkg::*;
#(
  parameter int          FIFO_WIDTH = 16,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [CNT_W-1:0]      num_ops,
  input  logic                  allow_ovf,
  input  logic                  flush_end,
  input  logic                  full,
  input  logic                  almostfull,
  input  logic                  empty,
  input  logic                  almostempty,
  input  logic                  wr_ack,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      wr_count,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      ack_count
);

  gen_state_e       state;
  gen_state_e       state_nxt;
  gen_mode_e        mode_q;
  gen_mode_e        sel_mode;
  logic             allow_q;
  logic             flush_q;
  logic             sel_allow;
  logic [CNT_W-1:0] slots;
  logic             idx_par;
  logic             par;
  logic             accept;
  logic             last;
  logic             draw;
  logic             want_wr;
  logic             want_rd;
  logic             wr_ok;
  logic             rd_ok;
  logic             wr_en_nxt;
  logic             rd_en_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [31:0]      lfsr_q;

  assign accept = (state == IDLE) & start;
  assign last   = (state == RUN) & (slots == CNT_W'(1));

  // steps on every drawn slot, including slot 0 at start
  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (draw | (state == RUN)),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_ops == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = flush_q ? FLUSH : DONE;
      end
      FLUSH: begin
        if (empty & ~rd_en) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // per-slot request, flag gating and next registered outputs
  always_comb begin
    sel_mode  = mode_q;
    sel_allow = allow_q;
    par       = ~idx_par;
    draw      = 1'b0;
    want_wr   = 1'b0;
    want_rd   = 1'b0;
    if (state == IDLE) begin
      sel_mode  = gen_mode_e'(mode);
      sel_allow = allow_ovf;
      par       = 1'b0;
      draw      = start & (num_ops != '0);
    end else if (state == RUN) begin
      draw = ~last;
    end
    unique case (sel_mode)
      FILL:  want_wr = 1'b1;
      DRAIN: want_rd = 1'b1;
      ALTERNATE: begin
        want_wr = ~par;
        want_rd = par;
      end
      RANDOM: begin
        want_wr = lfsr_q[0];
        want_rd = lfsr_q[1];
      end
      default: ;
    endcase
    wr_ok = sel_allow
          | (~full & ~(almostfull & wr_en & ~rd_en));
    rd_ok = sel_allow
          | (~empty & ~(almostempty & rd_en & ~wr_en));
    wr_en_nxt = draw & want_wr & wr_ok;
    rd_en_nxt = (draw & want_rd & rd_ok)
              | ((state == FLUSH) & ~empty & rd_ok);
    busy_nxt  = (state_nxt == RUN) | (state_nxt == FLUSH);
    done_nxt  = (state_nxt == DONE);
  end

  // registered FIFO-facing and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      data_in <= '0;
    end else begin
      wr_en <= wr_en_nxt;
      rd_en <= rd_en_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      if (wr_en_nxt) data_in <= lfsr_q[FIFO_WIDTH-1:0];
    end
  end

  // latched command and slot bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= FILL;
      allow_q <= 1'b0;
      flush_q <= 1'b0;
      slots   <= '0;
      idx_par <= 1'b0;
    end else if (accept) begin
      mode_q  <= gen_mode_e'(mode);
      allow_q <= allow_ovf;
      flush_q <= flush_end;
      slots   <= num_ops;
      idx_par <= 1'b0;
    end else if (state == RUN) begin
      slots   <= slots - CNT_W'(1);
      idx_par <= ~idx_par;
    end
  end

  // saturating run statistics, cleared by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count  <= '0;
      rd_count  <= '0;
      ack_count <= '0;
    end else if (accept) begin
      wr_count  <= CNT_W'(wr_en_nxt);
      rd_count  <= CNT_W'(rd_en_nxt);
      ack_count <= '0;
    end else begin
      if (wr_en_nxt && (wr_count != '1)) begin
        wr_count <= wr_count + CNT_W'(1);
      end
      if (rd_en_nxt && (rd_count != '1)) begin
        rd_count <= rd_count + CNT_W'(1);
      end
      if (wr_ack && (state != IDLE) && (ack_count != '1)) begin
        ack_count <= ack_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Directed bench: generator driving a depth-8 FIFO model.
// Each task checks its own scenario against hand-derived values.
module tb_fifo_traffic_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] num_ops;
  logic        allow_ovf;
  logic        flush_end;
  logic        full;
  logic        almostfull;
  logic        empty;
  logic        almostempty;
  logic        wr_ack;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic        busy;
  logic        done;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [15:0] ack_count;

  int n_cmp = 0;
  int n_err = 0;

  fifo_traffic_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .num_ops     (num_ops),
    .allow_ovf   (allow_ovf),
    .flush_end   (flush_end),
    .full        (full),
    .almostfull  (almostfull),
    .empty       (empty),
    .almostempty (almostempty),
    .wr_ack      (wr_ack),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .busy        (busy),
    .done        (done),
    .wr_count    (wr_count),
    .rd_count    (rd_count),
    .ack_count   (ack_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // depth-8 FIFO model
  logic [15:0] mem [8];
  logic [2:0]  wp;
  logic [2:0]  rp;
  int          cnt;
  logic        ovf;
  logic        udf;
  logic        rd_vld;
  logic [15:0] data_out;
  logic        w_ok;
  logic        r_ok;

  assign full        = (cnt == 8);
  assign almostfull  = (cnt == 7);
  assign empty       = (cnt == 0);
  assign almostempty = (cnt == 1);
  assign w_ok        = wr_en && (cnt < 8);
  assign r_ok        = rd_en && (cnt > 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 0;
      wp       <= 3'd0;
      rp       <= 3'd0;
      wr_ack   <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      rd_vld   <= 1'b0;
      data_out <= 16'd0;
    end else begin
      wr_ack <= w_ok;
      ovf    <= wr_en && !w_ok;
      udf    <= rd_en && !r_ok;
      rd_vld <= r_ok;
      if (w_ok) begin
        mem[wp] <= data_in;
        wp      <= wp + 3'd1;
      end
      if (r_ok) begin
        data_out <= mem[rp];
        rp       <= rp + 3'd1;
      end
      cnt <= cnt + (w_ok ? 1 : 0) - (r_ok ? 1 : 0);
    end
  end

  // running totals, sampled mid-cycle
  int          ovf_tot  = 0;
  int          udf_tot  = 0;
  int          both_tot = 0;
  int          done_tot = 0;
  logic [15:0] rd_log [$];

  always @(negedge clk) begin
    if (ovf) ovf_tot++;
    if (udf) udf_tot++;
    if (wr_en && rd_en) both_tot++;
    if (done) done_tot++;
    if (rd_vld) rd_log.push_back(data_out);
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic fb;
    fb = s[0];
    s  = s >> 1;
    if (fb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [1:0] m, input int n,
                          input logic ao, input logic fe);
    mode      = m;
    num_ops   = 16'(n);
    allow_ovf = ao;
    flush_end = fe;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout got no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({wr_en, rd_en, busy, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 0000", {wr_en, rd_en, busy, done});
    end
    n_cmp++;
    if (data_in !== 16'd0) begin
      n_err++;
      $display("FAIL reset_data got %h want 0000", data_in);
    end
    n_cmp++;
    if ({wr_count, rd_count, ack_count} !== 48'd0) begin
      n_err++;
      $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0",
               wr_count, rd_count, ack_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    int cyc;
    int b_ovf;
    apply_reset();
    b_ovf = ovf_tot;
    do_start(2'd0, 10, 1'b0, 1'b0);
    n_cmp++;
    if ({wr_en, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL fill_first_cycle got wr_en,busy=%b want 11", {wr_en, busy});
    end
    wait_done(40, cyc);
    n_cmp++;
    if (cyc != 10) begin
      n_err++;
      $display("FAIL fill_done_latency got %0d want 10", cyc);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL fill_done_pulse got done,busy=%b want 00", {done, busy});
    end
    n_cmp++;
    if (wr_count !== 16'd8) begin
      n_err++;
      $display("FAIL fill_wr_count got %0d want 8", wr_count);
    end
    n_cmp++;
    if (ack_count !== 16'd8) begin
      n_err++;
      $display("FAIL fill_ack_count got %0d want 8", ack_count);
    end
    n_cmp++;
    if (rd_count !== 16'd0) begin
      n_err++;
      $display("FAIL fill_rd_count got %0d want 0", rd_count);
    end
    n_cmp++;
    if ((ovf_tot - b_ovf) != 0) begin
      n_err++;
      $display("FAIL fill_no_ovf got %0d want 0", ovf_tot - b_ovf);
    end
    n_cmp++;
    if (full !== 1'b1) begin
      n_err++;
      $display("FAIL fill_full got %b want 1", full);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_count !== 16'd8) begin
      n_err++;
      $display("FAIL fill_hold got %0d want 8", wr_count);
    end
  endtask

  task automatic test_fill_ovf();
    int cyc;
    int b_ovf;
    apply_reset();
    b_ovf = ovf_tot;
    do_start(2'd0, 10, 1'b1, 1'b0);
    wait_done(40, cyc);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wr_count !== 16'd10) begin
      n_err++;
      $display("FAIL ovf_wr_count got %0d want 10", wr_count);
    end
    n_cmp++;
    if (ack_count !== 16'd8) begin
      n_err++;
      $display("FAIL ovf_ack_count got %0d want 8", ack_count);
    end
    n_cmp++;
    if ((ovf_tot - b_ovf) != 2) begin
      n_err++;
      $display("FAIL ovf_cycles got %0d want 2", ovf_tot - b_ovf);
    end
  endtask

  task automatic test_drain();
    int cyc;
    int b_udf;
    apply_reset();
    b_udf = udf_tot;
    do_start(2'd1, 4, 1'b1, 1'b0);
    wait_done(20, cyc);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rd_count !== 16'd4) begin
      n_err++;
      $display("FAIL drain_ovf_rd_count got %0d want 4", rd_count);
    end
    n_cmp++;
    if ((udf_tot - b_udf) != 4) begin
      n_err++;
      $display("FAIL drain_udf got %0d want 4", udf_tot - b_udf);
    end
    b_udf = udf_tot;
    do_start(2'd1, 4, 1'b0, 1'b0);
    wait_done(20, cyc);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rd_count !== 16'd0) begin
      n_err++;
      $display("FAIL drain_gated_rd_count got %0d want 0", rd_count);
    end
    n_cmp++;
    if ((udf_tot - b_udf) != 0) begin
      n_err++;
      $display("FAIL drain_gated_udf got %0d want 0", udf_tot - b_udf);
    end
  endtask

  task automatic test_alternate();
    int          cyc;
    int          b_log;
    logic [31:0] s;
    logic [15:0] exp_d [3];
    s        = 32'hACE1_2468;
    exp_d[0] = s[15:0];
    s        = lfsr_step(lfsr_step(s));
    exp_d[1] = s[15:0];
    s        = lfsr_step(lfsr_step(s));
    exp_d[2] = s[15:0];
    apply_reset();
    b_log = rd_log.size();
    do_start(2'd2, 6, 1'b0, 1'b1);
    wait_done(40, cyc);
    n_cmp++;
    if (cyc != 9) begin
      n_err++;
      $display("FAIL alt_done_latency got %0d want 9", cyc);
    end
    @(negedge clk);
    n_cmp++;
    if ({wr_count, rd_count} !== {16'd3, 16'd3}) begin
      n_err++;
      $display("FAIL alt_counts got %0d/%0d want 3/3", wr_count, rd_count);
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_err++;
      $display("FAIL alt_empty got %b want 1", empty);
    end
    n_cmp++;
    if (rd_log.size() - b_log != 3) begin
      n_err++;
      $display("FAIL alt_reads got %0d want 3", rd_log.size() - b_log);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (rd_log[b_log+i] !== exp_d[i]) begin
          n_err++;
          $display("FAIL alt_data%0d got %h want %h", i, rd_log[b_log+i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int          cyc;
    int          b_ovf;
    int          b_udf;
    int          b_both;
    logic [15:0] w1;
    logic [15:0] r1;
    apply_reset();
    b_ovf  = ovf_tot;
    b_udf  = udf_tot;
    b_both = both_tot;
    do_start(2'd3, 200, 1'b0, 1'b0);
    wait_done(400, cyc);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wr_count !== ack_count) begin
      n_err++;
      $display("FAIL rnd_ack got %0d want %0d", ack_count, wr_count);
    end
    n_cmp++;
    if ((ovf_tot - b_ovf) != 0 || (udf_tot - b_udf) != 0) begin
      n_err++;
      $display("FAIL rnd_flags got ovf=%0d udf=%0d want 0/0",
               ovf_tot - b_ovf, udf_tot - b_udf);
    end
    n_cmp++;
    if ((both_tot - b_both) == 0) begin
      n_err++;
      $display("FAIL rnd_both got 0 want >0");
    end
    w1 = wr_count;
    r1 = rd_count;
    apply_reset();
    do_start(2'd3, 200, 1'b0, 1'b0);
    wait_done(400, cyc);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({wr_count, rd_count} !== {w1, r1}) begin
      n_err++;
      $display("FAIL rnd_rerun got %0d/%0d want %0d/%0d",
               wr_count, rd_count, w1, r1);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int b_done;
    apply_reset();
    b_done = done_tot;
    do_start(2'd0, 10, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, rd_en, busy, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_ctrl got %b want 0000", {wr_en, rd_en, busy, done});
    end
    n_cmp++;
    if ({wr_count, data_in} !== 32'd0) begin
      n_err++;
      $display("FAIL abort_state got cnt=%0d data=%h want 0/0000", wr_count, data_in);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (done_tot != b_done) begin
      n_err++;
      $display("FAIL abort_no_done got %0d want 0", done_tot - b_done);
    end
    do_start(2'd0, 3, 1'b0, 1'b0);
    wait_done(20, cyc);
    @(negedge clk);
    n_cmp++;
    if ({wr_count, ack_count} !== {16'd3, 16'd3}) begin
      n_err++;
      $display("FAIL restart_counts got %0d/%0d want 3/3", wr_count, ack_count);
    end
    n_cmp++;
    if (done_tot - b_done != 1) begin
      n_err++;
      $display("FAIL restart_done got %0d want 1", done_tot - b_done);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    num_ops   = 16'd0;
    allow_ovf = 1'b0;
    flush_end = 1'b0;
    test_reset();
    test_fill();
    test_fill_ovf();
    test_drain();
    test_alternate();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
